// File: rtl/key_press_gen_pkg.sv
// Shared definitions for the emulated key press generator: FSM encoding,
// LFSR taps and seed, and the LFSR feedback helpers.
`timescale 1ns/1ps
package key_press_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    P_BOUNCE = 2'd1,
    HOLD     = 2'd2,
    R_BOUNCE = 2'd3
  } state_t;

  // Taps 16,14,13,11 of a 16-bit Fibonacci LFSR (bit 15 is tap 16).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic lfsr_fb(input logic [15:0] x);
    return ^(x & LFSR_TAPS);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], lfsr_fb(x)};
  endfunction

endpackage

// File: rtl/key_press_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per enabled cycle.
`timescale 1ns/1ps
module lfsr16
  import key_press_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  // An all-zero state would lock the register, so fall back to the default.
  localparam logic [15:0] INIT = (SEED == 16'd0) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= INIT;
    end else if (en) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign value = lfsr_reg;

endmodule

// File: rtl/key_press_gen.sv
// Emulates one active-low mechanical key press per start request:
// LFSR-driven press bounce, stable low hold, release bounce, back to idle.
`timescale 1ns/1ps
module key_press_gen
  import key_press_gen_pkg::*;
#(
  parameter logic [19:0] BOUNCE_MAX = 20'd249_999,
  parameter logic [7:0]  TOGGLE_DIV = 8'd99,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] hold_len,
  output logic        key_out,
  output logic        busy,
  output logic        done
);

  localparam logic [23:0] PHASE_END = {4'd0, BOUNCE_MAX};

  state_t      state_reg, state_next;
  logic [23:0] cnt_reg, cnt_next;
  logic [23:0] hold_reg, hold_next;
  logic [7:0]  div_reg, div_next;
  logic        key_reg, key_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        in_bounce;
  logic        tick;
  logic [15:0] lfsr_value;

  assign in_bounce = (state_reg == P_BOUNCE) || (state_reg == R_BOUNCE);
  assign tick      = (div_reg == TOGGLE_DIV);

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (in_bounce && tick),
    .value (lfsr_value)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hold_reg  <= '0;
      div_reg   <= '0;
      key_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
      div_reg   <= div_next;
      key_reg   <= key_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 24'd1;
    div_next   = tick ? 8'd0 : div_reg + 8'd1;
    hold_next  = hold_reg;
    key_next   = key_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        div_next = '0;
        // The completion cycle still counts as busy for new requests.
        if (start && !done_reg) begin
          state_next = P_BOUNCE;
          key_next   = 1'b0;
          busy_next  = 1'b1;
          hold_next  = (hold_len == 24'd0) ? 24'd1 : hold_len;
        end
      end
      P_BOUNCE: begin
        if (tick) begin
          key_next = lfsr_fb(lfsr_value);
        end
        if (cnt_reg == PHASE_END) begin
          state_next = HOLD;
          key_next   = 1'b0;
          cnt_next   = '0;
          div_next   = '0;
        end
      end
      HOLD: begin
        if (cnt_reg == hold_reg - 24'd1) begin
          state_next = R_BOUNCE;
          cnt_next   = '0;
          div_next   = '0;
        end
      end
      R_BOUNCE: begin
        if (tick) begin
          key_next = lfsr_fb(lfsr_value);
        end
        if (cnt_reg == PHASE_END) begin
          state_next = IDLE;
          key_next   = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          cnt_next   = '0;
          div_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign key_out = key_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_key_press_gen.sv
// Scoreboard bench for key_press_gen: per-cycle expectations of key_out,
// busy and done are queued at each accepted start and checked every cycle.
`timescale 1ns/1ps
module tb_key_press_gen;

  localparam int B       = 19;
  localparam int T       = 3;
  localparam int CNT_MAX = 9;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start     = 1'b0;
  logic [23:0] hold_len  = '0;
  logic        key_out;
  logic        busy;
  logic        done;

  always #5 sys_clk = ~sys_clk;

  key_press_gen #(
    .BOUNCE_MAX (20'd19),
    .TOGGLE_DIV (8'd3),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .hold_len  (hold_len),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic key;
    logic busy;
    logic done;
    logic first;
    logic pbounce;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          presses = 0;
  logic [15:0] m_lfsr  = 16'hACE1;
  logic [31:0] seq_cur  = '0;
  logic [31:0] seq_done = '0;
  logic [31:0] seq1, seq2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Expected samples taken 1 time unit after edges E..E+N of a press.
  task automatic push_press(input int h);
    int   hh;
    int   n;
    int   j;
    logic k;
    exp_t e;
    hh = (h == 0) ? 1 : h;
    n  = 2 * (B + 1) + hh;
    k  = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i == 0) begin
        k = 1'b0;
      end else if (i <= B + 1) begin
        if (i % (T + 1) == 0) begin
          m_lfsr = model_step(m_lfsr);
          k = m_lfsr[0];
        end
        if (i == B + 1) k = 1'b0;
      end else if (i > B + hh) begin
        j = i - (B + 1 + hh);
        if (j > 0 && j % (T + 1) == 0) begin
          m_lfsr = model_step(m_lfsr);
          k = m_lfsr[0];
        end
        if (j == B + 1) k = 1'b1;
      end
      e.key     = k;
      e.busy    = (i < n);
      e.done    = (i == n);
      e.first   = (i == 0);
      e.pbounce = (i <= B);
      exp_q.push_back(e);
    end
  endtask

  task automatic press(input int h);
    @(negedge sys_clk);
    start    = 1'b1;
    hold_len = 24'(h);
    push_press(h);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge sys_clk);
      c++;
    end
    check("wait_idle", exp_q.size(), 0);
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (sys_rst_n) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("key", {31'd0, key_out}, {31'd0, mon_e.key});
        check("busy", {31'd0, busy}, {31'd0, mon_e.busy});
        check("done", {31'd0, done}, {31'd0, mon_e.done});
        if (mon_e.first) seq_cur = '0;
        if (mon_e.pbounce) seq_cur = {seq_cur[30:0], key_out};
        if (mon_e.done) begin
          presses++;
          seq_done = seq_cur;
          $display("[TB] press %0d complete, bounce seq=%05h", presses, seq_cur);
        end
      end else begin
        check("idle_key", {31'd0, key_out}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
      end
    end
  end

  // Loopback debounce: state flips after CNT_MAX+1 consecutive differing cycles.
  logic db     = 1'b1;
  int   db_cnt = 0;
  int   flag_cnt = 0;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db     <= 1'b1;
      db_cnt <= 0;
    end else if (key_out == db) begin
      db_cnt <= 0;
    end else if (db_cnt == CNT_MAX) begin
      db     <= key_out;
      db_cnt <= 0;
      if (!key_out) flag_cnt <= flag_cnt + 1;
    end else begin
      db_cnt <= db_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_key", {31'd0, key_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // First press from the reset seed, looped into the debouncer.
    press(50);
    wait_idle();
    seq1 = seq_done;
    check("seq1_golden", seq1, 32'h000_FFF0);
    check("dbnc_flags", flag_cnt, 1);

    // Back-to-back press: LFSR continues, bounce pattern changes.
    press(50);
    wait_idle();
    seq2 = seq_done;
    check("seq_differ", {31'd0, seq1 != seq2}, 32'd1);

    // Zero hold length behaves as one cycle.
    press(0);
    wait_idle();

    // Starts during busy, hold_len change mid-press, start in done cycle.
    press(50);
    repeat (4) @(negedge sys_clk);
    start    = 1'b1;
    hold_len = 24'd7;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (24) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_idle();
    start = 1'b1;
    @(negedge sys_clk);
    hold_len = 24'd20;
    push_press(20);
    @(negedge sys_clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of the release bounce.
    press(30);
    repeat (55) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_key", {31'd0, key_out}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    m_lfsr = 16'hACE1;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    press(10);
    wait_idle();
    check("seq_after_rst", seq_done, 32'h000_FFF0);
    repeat (5) @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
